// File: rtl/counter_arbiter_if.sv
// Bundle of the requester handshake, counter hookup and completion signals around counter_arbiter.
// The arbiter connects through the slave modport; the surrounding logic uses master.
interface counter_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int CNT_W = 2,
    parameter int LEN_W = 4,
    parameter int ID_W  = $clog2(NREQ)
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*LEN_W-1:0] req_len;
    logic [NREQ-1:0]       req_ready;
    logic                  cnt_enable;
    logic [CNT_W-1:0]      cnt_value;
    logic                  done_valid;
    logic [ID_W-1:0]       done_id;
    logic [CNT_W-1:0]      done_value;
    logic                  busy;

    modport master (
        output req_valid, req_len, cnt_value,
        input  req_ready, cnt_enable, done_valid, done_id, done_value, busy
    );

    modport slave (
        input  req_valid, req_len, cnt_value,
        output req_ready, cnt_enable, done_valid, done_id, done_value, busy
    );
endinterface

// File: rtl/counter_arbiter.sv
// Round-robin scheduler that lends a shared up-counter to one requester at a time,
// enabling it for the requested number of cycles and reporting the final count.
module counter_arbiter #(
    parameter int NREQ  = 4,
    parameter int CNT_W = 2,
    parameter int LEN_W = 4,
    parameter int ID_W  = $clog2(NREQ)
) (
    input logic              clk,
    input logic              reset,
    counter_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    state_t            state_next;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   cur_id;
    logic [LEN_W-1:0]  remaining;

    logic              found;
    logic [ID_W-1:0]   winner;
    logic [LEN_W-1:0]  winner_len;
    logic [NREQ-1:0]   ready;
    int                scan_idx;

    // Scan requesters starting at ptr; the first valid one wins.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_idx = 0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = (int'(ptr) + k) % NREQ;
            if (!found && bus.req_valid[scan_idx]) begin
                found  = 1'b1;
                winner = ID_W'(scan_idx);
            end
        end
        winner_len = bus.req_len[int'(winner)*LEN_W +: LEN_W];
    end

    // The accept strobe is masked during reset so nothing appears granted while state is held.
    always_comb begin
        state_next = state;
        ready      = '0;
        case (state)
            IDLE: begin
                if (found && !reset) begin
                    ready[winner] = 1'b1;
                    state_next    = (winner_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (remaining == LEN_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            cur_id    <= '0;
            remaining <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (found) begin
                        cur_id    <= winner;
                        remaining <= winner_len;
                    end
                end
                RUN:  remaining <= remaining - LEN_W'(1);
                DONE: ptr <= ID_W'((int'(cur_id) + 1) % NREQ);
                default: ;
            endcase
        end
    end

    // done_value passes the counter straight through; all increments have landed by DONE.
    assign bus.req_ready  = ready;
    assign bus.cnt_enable = (state == RUN);
    assign bus.done_valid = (state == DONE);
    assign bus.done_id    = (state == DONE) ? cur_id : '0;
    assign bus.done_value = (state == DONE) ? bus.cnt_value : '0;
    assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_counter_arbiter.sv
// Randomised and directed bench for counter_arbiter, checked against a timestamp-based job model.
module tb_counter_arbiter;
    localparam int NREQ   = 4;
    localparam int CNT_W  = 2;
    localparam int LEN_W  = 4;
    localparam int ID_W   = 2;
    localparam int QDEPTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             cnt_rst;
    logic [CNT_W-1:0] counter;

    counter_arbiter_if #(.NREQ(NREQ), .CNT_W(CNT_W), .LEN_W(LEN_W), .ID_W(ID_W)) bus ();

    counter_arbiter #(.NREQ(NREQ), .CNT_W(CNT_W), .LEN_W(LEN_W), .ID_W(ID_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Stand-in for the shared counter instance; only its own reset clears it.
    always @(posedge clk) begin
        if (cnt_rst) counter <= '0;
        else if (bus.cnt_enable) counter <= counter + CNT_W'(1);
    end
    assign bus.cnt_value = counter;

    int checks = 0;
    int errors = 0;

    logic [LEN_W-1:0] fifo [NREQ][QDEPTH];
    int q_rd [NREQ];
    int q_wr [NREQ];

    int cyc = 0;
    bit m_active = 1'b0;
    int m_t, m_len, m_id;
    int m_ptr = 0;
    int m_count = 0;

    // Requesters must hold their length stable while waiting to be accepted.
    logic [NREQ-1:0]       prev_valid;
    logic [NREQ-1:0]       prev_ready;
    logic [NREQ*LEN_W-1:0] prev_len;
    always @(negedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (prev_valid[i] === 1'b1 && prev_ready[i] === 1'b0 && bus.req_valid[i] === 1'b1 &&
                prev_len[i*LEN_W +: LEN_W] !== bus.req_len[i*LEN_W +: LEN_W])
                $error("[TB] req_len of requester %0d changed while waiting", i);
        end
        prev_valid = bus.req_valid;
        prev_ready = bus.req_ready;
        prev_len   = bus.req_len;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, actual, expected);
        end
    endtask

    task automatic push(input int id, input int len);
        fifo[id][q_wr[id] % QDEPTH] = LEN_W'(len);
        q_wr[id]++;
    endtask

    // One clock cycle: drive requests from the queues, check outputs, advance the job model.
    task automatic applyStimulus(input bit rst, input bit crst);
        logic [NREQ-1:0]       v;
        logic [NREQ*LEN_W-1:0] l;
        logic [NREQ-1:0]       exp_ready;
        bit                    exp_en, exp_done, exp_busy, found;
        int                    exp_id, exp_val, win, idx;
        @(posedge clk);
        #1;
        reset   = rst;
        cnt_rst = crst;
        v = '0;
        l = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (q_wr[i] != q_rd[i]) begin
                v[i] = 1'b1;
                l[i*LEN_W +: LEN_W] = fifo[i][q_rd[i] % QDEPTH];
            end
        end
        bus.req_valid = v;
        bus.req_len   = l;
        @(negedge clk);

        exp_ready = '0;
        exp_en = 1'b0; exp_done = 1'b0; exp_busy = 1'b0; found = 1'b0;
        exp_id = 0; exp_val = 0; win = 0;
        if (m_active) begin
            exp_busy = 1'b1;
            exp_en   = (cyc >= m_t + 1) && (cyc <= m_t + m_len);
            exp_done = (cyc == m_t + m_len + 1);
            if (exp_done) begin
                exp_id  = m_id;
                exp_val = m_count;
            end
        end else if (!rst) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                if (!found && v[idx]) begin
                    found = 1'b1;
                    win   = idx;
                end
            end
            if (found) exp_ready[win] = 1'b1;
        end

        checkOutput("req_ready",  32'(bus.req_ready),  32'(exp_ready));
        checkOutput("cnt_enable", 32'(bus.cnt_enable), 32'(exp_en));
        checkOutput("done_valid", 32'(bus.done_valid), 32'(exp_done));
        checkOutput("done_id",    32'(bus.done_id),    32'(exp_id));
        checkOutput("done_value", 32'(bus.done_value), 32'(exp_val));
        checkOutput("busy",       32'(bus.busy),       32'(exp_busy));

        if (exp_en) m_count = (m_count + 1) % (1 << CNT_W);
        if (crst) m_count = 0;
        if (m_active && exp_done) begin
            m_active = 1'b0;
            m_ptr    = (m_id + 1) % NREQ;
        end else if (!m_active && found) begin
            m_active = 1'b1;
            m_t      = cyc;
            m_len    = int'(l[win*LEN_W +: LEN_W]);
            m_id     = win;
            q_rd[win]++;
        end
        if (rst) begin
            m_active = 1'b0;
            m_ptr    = 0;
        end
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        cnt_rst = 1'b1;
        bus.req_valid = '0;
        bus.req_len = '0;
        for (int i = 0; i < NREQ; i++) begin
            q_rd[i] = 0;
            q_wr[i] = 0;
        end

        // Reset with everyone requesting, then round robin 0,1,2,3,0 with len=1 and wrap.
        for (int i = 0; i < NREQ; i++) push(i, 1);
        push(0, 1);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1);
        run(20);

        // Requester 0 alone, len=3, counter from 0.
        applyStimulus(1'b0, 1'b1);
        push(0, 3);
        run(8);

        // Requester 2 alone, len=5; then 0 and 3 together, 3 should win.
        applyStimulus(1'b1, 1'b1);
        push(2, 5);
        run(9);
        push(0, 2);
        push(3, 2);
        run(12);

        // Zero-length job.
        push(1, 0);
        run(4);

        // Reset in the middle of a long job; requester 0 wins again afterwards.
        applyStimulus(1'b1, 1'b0);
        push(0, 6);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        push(1, 1);
        push(0, 1);
        run(10);

        // Random traffic with occasional resets of the arbiter and counter.
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 7) == 0 && (q_wr[i] - q_rd[i]) < 3)
                    push(i, int'($urandom_range(0, 7)));
            end
            applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 99) == 0);
        end
        run(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
